wb_dmem_bus_if: RTL and testbench
=================================

Name: wb_dmem_bus_if

Overview:
- Data-side bus interface directly downstream of the memory-access stage.
- Accepts that stage's RAM request (ce, we, addr, sel, write data) and runs it as a single classic Wishbone read or write cycle.
- Holds the pipeline via stallreq_o until ack, then returns read data to the memory stage for load alignment and sign extension.
- Handles pipeline stall and flush interaction, plus a bus timeout.

Parameters:
- TIMEOUT_CYCLES, 255: cycles waited for wb_ack_i before the cycle is aborted with a bus error. Legal range 1..65535.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  reset, asynchronous, active-low
- stall_i  input  1  pipeline controller holds the memory stage this cycle
- flush_i  input  1  pipeline flush (exception); cancels any request
- cpu_ce_i  input  1  request valid
- cpu_we_i  input  1  1 = store, 0 = load
- cpu_addr_i  input  32  byte address (alignment already resolved upstream)
- cpu_sel_i  input  4  byte lanes; bit 3 = bits 31:24
- cpu_data_i  input  32  store data, lane-replicated
- cpu_data_o  output  32  load data returned to the memory stage
- stallreq_o  output  1  request pipeline stall (combinational)
- bus_err_o  output  1  one-cycle pulse on timeout abort
- wb_adr_o  output  32  Wishbone address
- wb_dat_o  output  32  Wishbone write data
- wb_dat_i  input  32  Wishbone read data
- wb_we_o  output  1  Wishbone write enable
- wb_sel_o  output  4  Wishbone byte select
- wb_stb_o  output  1  Wishbone strobe
- wb_cyc_o  output  1  Wishbone cycle
- wb_ack_i  input  1  Wishbone acknowledge

Behaviour:
Reset (rst=0, asynchronous):
- State = IDLE.
- All wb_* outputs 0.
- Read buffer = 0, timeout counter = 0.
- cpu_data_o = 0, bus_err_o = 0.
- stallreq_o = 0 while in reset.

State machine, registered; three states IDLE, BUSY, WAIT_STALL.

IDLE:
- If cpu_ce_i=1 and flush_i=0: on the next edge, register wb_adr_o/wb_dat_o/wb_we_o/wb_sel_o from the cpu_* inputs, set wb_stb_o = wb_cyc_o = 1, clear the counter, go to BUSY.
- stallreq_o = cpu_ce_i & ~flush_i (combinational, same cycle as the request).
- cpu_data_o = read buffer.

BUSY:
- Bus outputs hold stable until ack, flush or timeout.
- stallreq_o = 1, except 0 in the cycle wb_ack_i=1.
- On wb_ack_i=1:
  - cpu_data_o = wb_dat_i combinationally in that cycle.
  - Next edge: read buffer <= wb_dat_i (loads only; stores leave the buffer unchanged), wb_* <= 0.
  - Next state = WAIT_STALL if stall_i=1, else IDLE.
- flush_i=1 without ack: next edge wb_* <= 0, go to IDLE, buffer unchanged, stallreq_o = 0 that cycle. Flush takes priority over timeout.
- flush_i=1 with ack in the same cycle: treated as ack (the store completes). Next state is IDLE regardless of stall_i.
- Counter increments each BUSY cycle without ack. When counter = TIMEOUT_CYCLES-1 and no ack:
  - Next edge: wb_* <= 0, buffer <= 0xFFFFFFFF, bus_err_o pulses 1 for one cycle, go to IDLE.
  - stallreq_o = 0 in that cycle.

WAIT_STALL:
- Bus idle, stallreq_o = 0, cpu_data_o = read buffer.
- Stays until stall_i=0, then IDLE next edge.
- A flush moves directly to IDLE.
- Purpose: the completed access is never reissued while the pipeline is frozen on an older request.

Timing and protocol rules:
- Minimum latency: request in cycle N, bus asserted in N+1; ack in N+1 releases the stall in N+1. A zero-wait slave therefore costs one stall cycle.
- wb_cyc_o always equals wb_stb_o; there are no back-to-back cycles without an intervening IDLE cycle.
- wb_ack_i outside BUSY is ignored.
- Reset mid-cycle drops stb/cyc immediately (asynchronous).

Test Plan:
- Load, zero-wait: ce=1, we=0, addr=0x00000104, sel=4'b1111; slave acks in the first bus cycle with 0xDEADBEEF -> wb_adr_o=0x104, stb/cyc high for 1 cycle, stallreq_o high 1 cycle, cpu_data_o=0xDEADBEEF in the ack cycle and held afterwards.
- Store, 3 wait states: we=1, sel=4'b0100, data=0x5A5A5A5A -> wb_we_o=1, wb_sel_o=0100, outputs stable for 4 cycles, stallreq_o high 4 cycles, read buffer unchanged.
- Ack coinciding with stall_i=1 for 3 more cycles -> FSM in WAIT_STALL for 3 cycles, stb stays 0, no second bus cycle; IDLE one cycle after stall_i falls.
- Flush in the second BUSY cycle with no ack -> stb/cyc drop next edge, stallreq_o=0 in the flush cycle, state IDLE, no bus_err_o.
- Timeout with TIMEOUT_CYCLES=4 and a slave that never acks -> stb high exactly 4 cycles, bus_err_o single pulse, cpu_data_o=0xFFFFFFFF, IDLE.
- Async reset asserted mid-BUSY -> wb_stb_o/wb_cyc_o/stallreq_o 0 without waiting for a clock edge; after release, a new request runs normally.

Source files
------------

// File: rtl/wb_dmem_bus_if.sv
// Data-side Wishbone classic master for the memory stage: one bus cycle per request,
// with pipeline stall handshake, flush cancellation and an ack timeout.
module wb_dmem_bus_if #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        cpu_ce_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [3:0]  cpu_sel_i,
  input  logic [31:0] cpu_data_i,
  output logic [31:0] cpu_data_o,
  output logic        stallreq_o,
  output logic        bus_err_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic        wb_ack_i
);

  localparam logic [15:0] CntMax = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StWaitStall} state_e;

  state_e      state_q, state_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic        stb_q, stb_d;
  logic [31:0] rbuf_q, rbuf_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        stallreq;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      adr_q   <= '0;
      dat_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      stb_q   <= 1'b0;
      rbuf_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      stb_q   <= stb_d;
      rbuf_q  <= rbuf_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    we_d       = we_q;
    sel_d      = sel_q;
    stb_d      = stb_q;
    rbuf_d     = rbuf_q;
    cnt_d      = cnt_q;
    err_d      = 1'b0;
    stallreq   = 1'b0;
    cpu_data_o = rbuf_q;

    case (state_q)
      StIdle: begin
        if (cpu_ce_i && !flush_i) begin
          stallreq = 1'b1;
          adr_d    = cpu_addr_i;
          dat_d    = cpu_data_i;
          we_d     = cpu_we_i;
          sel_d    = cpu_sel_i;
          stb_d    = 1'b1;
          cnt_d    = '0;
          state_d  = StBusy;
        end
      end
      StBusy: begin
        if (wb_ack_i) begin
          // Ack wins over a simultaneous flush: the access has already happened.
          cpu_data_o = wb_dat_i;
          if (!we_q) rbuf_d = wb_dat_i;
          {adr_d, dat_d, we_d, sel_d, stb_d} = '0;
          state_d = (stall_i && !flush_i) ? StWaitStall : StIdle;
        end else if (flush_i) begin
          {adr_d, dat_d, we_d, sel_d, stb_d} = '0;
          state_d = StIdle;
        end else if (cnt_q == CntMax) begin
          {adr_d, dat_d, we_d, sel_d, stb_d} = '0;
          rbuf_d  = '1;
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          stallreq = 1'b1;
          cnt_d    = cnt_q + 16'd1;
        end
      end
      StWaitStall: begin
        // Hold off until the pipeline moves past the completed request.
        if (flush_i || !stall_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign stallreq_o = stallreq & rst;
  assign bus_err_o  = err_q;
  assign wb_adr_o   = adr_q;
  assign wb_dat_o   = dat_q;
  assign wb_we_o    = we_q;
  assign wb_sel_o   = sel_q;
  assign wb_stb_o   = stb_q;
  assign wb_cyc_o   = stb_q;

endmodule

// File: tb/tb_wb_dmem_bus_if.sv
// Randomised bench for wb_dmem_bus_if: drives memory-stage requests and a scripted
// slave, checking against a transaction-level model of the read buffer and error pulse.
module tb_wb_dmem_bus_if;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i, flush_i, cpu_ce_i, cpu_we_i;
  logic [31:0] cpu_addr_i, cpu_data_i, cpu_data_o;
  logic [3:0]  cpu_sel_i;
  logic        stallreq_o, bus_err_o;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic        wb_we_o, wb_stb_o, wb_cyc_o, wb_ack_i;
  logic [3:0]  wb_sel_o;

  int          chk_cnt = 0;
  int          pass_cnt = 0;
  logic [31:0] exp_buf = '0;
  logic        err_exp = 1'b0;
  int          last_busy = 0;

  wb_dmem_bus_if #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .stall_i   (stall_i),
    .flush_i   (flush_i),
    .cpu_ce_i  (cpu_ce_i),
    .cpu_we_i  (cpu_we_i),
    .cpu_addr_i(cpu_addr_i),
    .cpu_sel_i (cpu_sel_i),
    .cpu_data_i(cpu_data_i),
    .cpu_data_o(cpu_data_o),
    .stallreq_o(stallreq_o),
    .bus_err_o (bus_err_o),
    .wb_adr_o  (wb_adr_o),
    .wb_dat_o  (wb_dat_o),
    .wb_dat_i  (wb_dat_i),
    .wb_we_o   (wb_we_o),
    .wb_sel_o  (wb_sel_o),
    .wb_stb_o  (wb_stb_o),
    .wb_cyc_o  (wb_cyc_o),
    .wb_ack_i  (wb_ack_i)
  );

  always #5 clk = ~clk;

  // One memory-stage request: request cycle, bus cycles until ack/flush/timeout, then any
  // frozen-pipeline cycles. Caller guarantees the interface is idle beforehand.
  task automatic xfer(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                      input logic [31:0] wdata, input logic [31:0] rdata, input int waits,
                      input int flush_at, input int stall_extra, input string name);
    int k;
    bit done, ack, flush, tmo;
    @(posedge clk); #1;
    cpu_ce_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_sel_i = sel; cpu_data_i = wdata;
    flush_i = 1'b0; stall_i = 1'b0; wb_ack_i = 1'b0; wb_dat_i = $urandom;
    @(negedge clk);
    chk_cnt++;
    if ({wb_stb_o, wb_cyc_o, stallreq_o, bus_err_o, cpu_data_o} !==
        {1'b0, 1'b0, 1'b1, err_exp, exp_buf})
      $display("FAIL %s req: stb,cyc,stallreq,err,data=%b%b%b%b %h required 001%b %h", name,
               wb_stb_o, wb_cyc_o, stallreq_o, bus_err_o, cpu_data_o, err_exp, exp_buf);
    else pass_cnt++;
    err_exp = 1'b0;
    k = 0; done = 0; ack = 0; flush = 0;
    while (!done) begin
      @(posedge clk); #1;
      ack   = (k == waits);
      flush = (k == flush_at);
      tmo   = !ack && !flush && (k == TMO - 1);
      wb_ack_i = ack; flush_i = flush; stall_i = ack && (stall_extra > 0);
      wb_dat_i = ack ? rdata : $urandom;
      @(negedge clk);
      chk_cnt++;
      if ({wb_stb_o, wb_cyc_o, stallreq_o, bus_err_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o} !==
          {2'b11, !(ack || flush || tmo), 1'b0, we, sel, addr, wdata})
        $display("FAIL %s bus[%0d]: stb,cyc,stallreq,err=%b%b%b%b we=%b sel=%b adr=%h dat=%h required 11%b0 we=%b sel=%b adr=%h dat=%h",
                 name, k, wb_stb_o, wb_cyc_o, stallreq_o, bus_err_o, wb_we_o, wb_sel_o, wb_adr_o,
                 wb_dat_o, !(ack || flush || tmo), we, sel, addr, wdata);
      else pass_cnt++;
      chk_cnt++;
      if (cpu_data_o !== (ack ? rdata : exp_buf))
        $display("FAIL %s data[%0d]: cpu_data_o=%h required %h", name, k, cpu_data_o,
                 ack ? rdata : exp_buf);
      else pass_cnt++;
      if (ack && !we) exp_buf = rdata;
      if (tmo) begin exp_buf = 32'hFFFF_FFFF; err_exp = 1'b1; end
      done = ack || flush || tmo;
      k++;
      if (!done && k > TMO + 2) begin
        chk_cnt++;
        $display("FAIL %s bound: cycle still open after %0d bus cycles, required end", name, k);
        done = 1;
      end
    end
    last_busy = k;
    if (ack && !flush && stall_extra > 0) begin
      for (int i = 0; i <= stall_extra; i++) begin
        @(posedge clk); #1;
        stall_i = (i < stall_extra); flush_i = 1'b0;
        wb_ack_i = 1'($urandom % 2); wb_dat_i = $urandom;
        @(negedge clk);
        chk_cnt++;
        if ({wb_stb_o, wb_cyc_o, stallreq_o, bus_err_o, cpu_data_o} !== {4'b0000, exp_buf})
          $display("FAIL %s hold[%0d]: stb,cyc,stallreq,err,data=%b%b%b%b %h required 0000 %h",
                   name, i, wb_stb_o, wb_cyc_o, stallreq_o, bus_err_o, cpu_data_o, exp_buf);
        else pass_cnt++;
      end
    end
  endtask

  task automatic idle(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      cpu_ce_i = 1'b0; flush_i = 1'b0; stall_i = 1'($urandom % 2);
      wb_ack_i = 1'($urandom % 2); wb_dat_i = $urandom;
      @(negedge clk);
      chk_cnt++;
      if ({wb_stb_o, wb_cyc_o, stallreq_o, bus_err_o, cpu_data_o} !==
          {3'b000, err_exp, exp_buf})
        $display("FAIL %s idle[%0d]: stb,cyc,stallreq,err,data=%b%b%b%b %h required 000%b %h",
                 name, i, wb_stb_o, wb_cyc_o, stallreq_o, bus_err_o, cpu_data_o, err_exp, exp_buf);
      else pass_cnt++;
      err_exp = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; cpu_ce_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 32'h1234_5678;
    cpu_sel_i = 4'hF; cpu_data_i = 32'hCAFE_F00D; flush_i = 1'b0; stall_i = 1'b0;
    wb_ack_i = 1'b1; wb_dat_i = 32'h1111_1111;
    repeat (3) @(negedge clk);
    chk_cnt++;
    if ({wb_stb_o, wb_cyc_o, wb_we_o, stallreq_o, bus_err_o, wb_sel_o, wb_adr_o, wb_dat_o,
         cpu_data_o} !== '0)
      $display("FAIL reset: stb,cyc,we,stallreq,err=%b%b%b%b%b sel=%b adr=%h dat=%h data=%h required all 0",
               wb_stb_o, wb_cyc_o, wb_we_o, stallreq_o, bus_err_o, wb_sel_o, wb_adr_o, wb_dat_o,
               cpu_data_o);
    else pass_cnt++;
    cpu_ce_i = 1'b0; wb_ack_i = 1'b0;
    rst = 1'b1;
    exp_buf = '0; err_exp = 1'b0;
    idle(2, "post_reset");
  endtask

  task automatic test_load_zero_wait();
    xfer(1'b0, 32'h0000_0104, 4'b1111, $urandom, 32'hDEAD_BEEF, 0, -1, 0, "load0");
    chk_cnt++;
    if (last_busy !== 1) $display("FAIL load0 len: bus cycles=%0d required 1", last_busy);
    else pass_cnt++;
    idle(2, "load0_hold");
  endtask

  task automatic test_store_waits();
    xfer(1'b1, 32'h0000_2008, 4'b0100, 32'h5A5A_5A5A, $urandom, 3, -1, 0, "store3");
    chk_cnt++;
    if (last_busy !== 4) $display("FAIL store3 len: bus cycles=%0d required 4", last_busy);
    else pass_cnt++;
    idle(1, "store3_buf");
  endtask

  task automatic test_back_to_back();
    xfer(1'b0, 32'h0000_0010, 4'b0011, $urandom, 32'h0102_0304, 0, -1, 0, "b2b_a");
    xfer(1'b0, 32'h0000_0014, 4'b1100, $urandom, 32'hA0B0_C0D0, 1, -1, 0, "b2b_b");
  endtask

  task automatic test_wait_stall();
    xfer(1'b0, 32'h0000_0300, 4'b1111, $urandom, 32'h7654_3210, 1, -1, 3, "wstall");
    xfer(1'b1, 32'h0000_0304, 4'b0001, 32'h0000_00AB, $urandom, 0, 0, 2, "ack_flush");
    idle(1, "ack_flush_idle");
  endtask

  task automatic test_flush();
    xfer(1'b0, 32'h0000_0400, 4'b1111, $urandom, $urandom, 9, 1, 0, "flush");
    idle(1, "flush_idle");
    @(posedge clk); #1;
    cpu_ce_i = 1'b1; cpu_we_i = 1'b0; flush_i = 1'b1; wb_ack_i = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (stallreq_o !== 1'b0) $display("FAIL flush_req: stallreq_o=%b required 0", stallreq_o);
    else pass_cnt++;
    idle(1, "flush_req_nobus");
  endtask

  task automatic test_timeout();
    xfer(1'b0, 32'h0000_0500, 4'b1111, $urandom, $urandom, 99, -1, 0, "timeout");
    chk_cnt++;
    if (last_busy !== TMO) $display("FAIL timeout len: bus cycles=%0d required %0d", last_busy, TMO);
    else pass_cnt++;
    idle(2, "timeout_after");
  endtask

  task automatic test_async_reset();
    xfer(1'b1, 32'h0000_0600, 4'b1111, 32'h1357_9BDF, $urandom, 1, -1, 0, "pre_rst");
    @(posedge clk); #1;
    cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_0700; wb_ack_i = 1'b0;
    @(posedge clk); #1;
    chk_cnt++;
    if ({wb_stb_o, stallreq_o} !== 2'b11)
      $display("FAIL rst_busy: stb,stallreq=%b%b required 11", wb_stb_o, stallreq_o);
    else pass_cnt++;
    #2 rst = 1'b0;
    #1;
    chk_cnt++;
    if ({wb_stb_o, wb_cyc_o, stallreq_o, cpu_data_o} !== {3'b000, 32'h0})
      $display("FAIL async_rst: stb,cyc,stallreq,data=%b%b%b %h required 000 0",
               wb_stb_o, wb_cyc_o, stallreq_o, cpu_data_o);
    else pass_cnt++;
    exp_buf = '0; err_exp = 1'b0;
    @(negedge clk);
    cpu_ce_i = 1'b0;
    rst = 1'b1;
    xfer(1'b0, 32'h0000_0704, 4'b1111, $urandom, 32'h2468_ACE0, 2, -1, 0, "post_rst");
  endtask

  task automatic test_random();
    int waits, flush_at, stall_extra;
    for (int i = 0; i < 40; i++) begin
      waits       = $urandom_range(0, 5);
      flush_at    = ($urandom % 4 == 0) ? int'($urandom_range(0, 3)) : -1;
      stall_extra = ($urandom % 3 == 0) ? int'($urandom_range(1, 3)) : 0;
      xfer(1'($urandom % 2), $urandom, 4'($urandom), $urandom, $urandom, waits, flush_at,
           stall_extra, "random");
      if ($urandom % 3 == 0) idle(int'($urandom_range(1, 2)), "random_gap");
    end
  endtask

  initial begin
    test_reset();
    test_load_zero_wait();
    test_store_waits();
    test_back_to_back();
    test_wait_stall();
    test_flush();
    test_timeout();
    test_async_reset();
    test_random();
    idle(2, "final");
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
